// File: rtl/mem_test_pkg.sv
// Shared types and constants for the AXI memory burst tester.
package mem_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WA,
        ST_WD,
        ST_WB,
        ST_RA,
        ST_RD,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_INCR = 2'd0;
    localparam logic [1:0] MODE_WALK = 2'd1;
    localparam logic [1:0] MODE_ADDR = 2'd2;
    localparam logic [1:0] MODE_NINC = 2'd3;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
    localparam int         AXI_ID_W       = 4;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Stateless data pattern generator: the read pass regenerates exactly what the
// write pass produced from (mode, seed, beat index/address).
module mem_pattern_gen
    import mem_test_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 31,
    parameter int IDX_W  = 9
) (
    input  logic [1:0]        i_mode,
    input  logic [31:0]       i_seed,
    input  logic [IDX_W-1:0]  i_beat_idx,
    input  logic [ADDR_W-1:0] i_beat_addr,
    output logic [DATA_W-1:0] o_pattern
);

    localparam int SH_W = $clog2(DATA_W);

    logic [31:0]     w_incr;
    logic [31:0]     w_word;
    logic [SH_W-1:0] w_walk_sh;

    // 32-bit word replicated across the bus; walking-one spans the full width.
    always_comb begin
        w_incr    = 32'(i_beat_idx) + i_seed;
        w_walk_sh = SH_W'(i_beat_idx);
        case (i_mode)
            MODE_ADDR: w_word = 32'(i_beat_addr) ^ i_seed;
            MODE_NINC: w_word = ~w_incr;
            default:   w_word = w_incr;
        endcase
        if (i_mode == MODE_WALK)
            o_pattern = {{(DATA_W-1){1'b0}}, 1'b1} << w_walk_sh;
        else
            o_pattern = {(DATA_W/32){w_word}};
    end

endmodule

// File: rtl/axi_mem_burst_tester.sv
// AXI4 memory self-test master: writes a pattern over a region in INCR bursts,
// reads it back and reports mismatches, first failing address and bad responses.
module axi_mem_burst_tester
    import mem_test_pkg::*;
#(
    parameter int ADDR_W     = 31,
    parameter int DATA_W     = 512,
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 64,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [1:0]           mode,
    input  logic [31:0]          seed,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic                 resp_err,
    // write address
    output logic [ADDR_W-1:0]    s_axi_awaddr,
    output logic [7:0]           s_axi_awlen,
    output logic [2:0]           s_axi_awsize,
    output logic [1:0]           s_axi_awburst,
    output logic [3:0]           s_axi_awcache,
    output logic [AXI_ID_W-1:0]  s_axi_awid,
    output logic                 s_axi_awlock,
    output logic [2:0]           s_axi_awprot,
    output logic [3:0]           s_axi_awqos,
    output logic                 s_axi_awvalid,
    input  logic                 s_axi_awready,
    // write data
    output logic [DATA_W-1:0]    s_axi_wdata,
    output logic [DATA_W/8-1:0]  s_axi_wstrb,
    output logic                 s_axi_wlast,
    output logic                 s_axi_wvalid,
    input  logic                 s_axi_wready,
    // write response
    input  logic [AXI_ID_W-1:0]  s_axi_bid,
    input  logic [1:0]           s_axi_bresp,
    input  logic                 s_axi_bvalid,
    output logic                 s_axi_bready,
    // read address
    output logic [ADDR_W-1:0]    s_axi_araddr,
    output logic [7:0]           s_axi_arlen,
    output logic [2:0]           s_axi_arsize,
    output logic [1:0]           s_axi_arburst,
    output logic [3:0]           s_axi_arcache,
    output logic [AXI_ID_W-1:0]  s_axi_arid,
    output logic                 s_axi_arlock,
    output logic [2:0]           s_axi_arprot,
    output logic [3:0]           s_axi_arqos,
    output logic                 s_axi_arvalid,
    input  logic                 s_axi_arready,
    // read data
    input  logic [DATA_W-1:0]    s_axi_rdata,
    input  logic [AXI_ID_W-1:0]  s_axi_rid,
    input  logic [1:0]           s_axi_rresp,
    input  logic                 s_axi_rlast,
    input  logic                 s_axi_rvalid,
    output logic                 s_axi_rready
);

    localparam int BEAT_BYTES  = DATA_W / 8;
    localparam int AXSIZE      = $clog2(BEAT_BYTES);
    localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int BEAT_W      = cnt_w(BURST_LEN);
    localparam int BURST_W     = cnt_w(NUM_BURSTS);
    localparam int IDX_W       = cnt_w(NUM_BURSTS * BURST_LEN);

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);

    state_t                r_state, w_state;
    logic [ADDR_W-1:0]     r_addr, w_addr;
    logic [ADDR_W-1:0]     r_base, w_base;
    logic [1:0]            r_mode, w_mode;
    logic [31:0]           r_seed, w_seed;
    logic [BURST_W-1:0]    r_burst, w_burst;
    logic [BEAT_W-1:0]     r_beat, w_beat;
    logic                  r_awvalid, w_awvalid;
    logic                  r_wvalid, w_wvalid;
    logic                  r_wlast, w_wlast;
    logic                  r_bready, w_bready;
    logic                  r_arvalid, w_arvalid;
    logic                  r_rready, w_rready;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  r_resp_err, w_resp_err;
    logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt;
    logic [ADDR_W-1:0]     r_first_err, w_first_err;

    logic [BEAT_W-1:0]     w_beat_inc;
    logic                  w_last_beat;
    logic                  w_last_burst;
    logic [IDX_W-1:0]      w_idx;
    logic [ADDR_W-1:0]     w_beat_addr;
    logic [DATA_W-1:0]     w_pattern;
    logic                  w_mismatch;
    logic                  w_unused;

    // Global beat index and byte address are derived from registered state only,
    // so the pattern (and wdata) never depends combinationally on AXI inputs.
    assign w_beat_inc   = r_beat + 1'b1;
    assign w_last_beat  = (r_beat == LAST_BEAT);
    assign w_last_burst = (r_burst == LAST_BURST);
    assign w_idx        = IDX_W'(r_burst) * IDX_W'(BURST_LEN) + IDX_W'(r_beat);
    assign w_beat_addr  = r_addr + (ADDR_W'(r_beat) << AXSIZE);

    mem_pattern_gen #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_pat (
        .i_mode      (r_mode),
        .i_seed      (r_seed),
        .i_beat_idx  (w_idx),
        .i_beat_addr (w_beat_addr),
        .o_pattern   (w_pattern)
    );

    // Data mismatch or rlast disagreeing with the expected burst end both count.
    assign w_mismatch = (s_axi_rdata != w_pattern) || (s_axi_rlast != w_last_beat);

    // Next-state and next-output logic; every output comes from a register.
    always_comb begin
        w_state     = r_state;
        w_addr      = r_addr;
        w_base      = r_base;
        w_mode      = r_mode;
        w_seed      = r_seed;
        w_burst     = r_burst;
        w_beat      = r_beat;
        w_awvalid   = r_awvalid;
        w_wvalid    = r_wvalid;
        w_wlast     = r_wlast;
        w_bready    = r_bready;
        w_arvalid   = r_arvalid;
        w_rready    = r_rready;
        w_busy      = r_busy;
        w_done      = r_done;
        w_resp_err  = r_resp_err;
        w_err_cnt   = r_err_cnt;
        w_first_err = r_first_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_base      = base_addr;
                    w_addr      = base_addr;
                    w_mode      = mode;
                    w_seed      = seed;
                    w_burst     = '0;
                    w_beat      = '0;
                    w_err_cnt   = '0;
                    w_first_err = '0;
                    w_resp_err  = 1'b0;
                    w_busy      = 1'b1;
                    w_done      = 1'b0;
                    w_awvalid   = 1'b1;
                    w_state     = ST_WA;
                end
            end
            ST_WA: begin
                if (s_axi_awready) begin
                    w_awvalid = 1'b0;
                    w_wvalid  = 1'b1;
                    w_wlast   = (BURST_LEN == 1);
                    w_beat    = '0;
                    w_state   = ST_WD;
                end
            end
            ST_WD: begin
                if (s_axi_wready) begin
                    if (w_last_beat) begin
                        w_wvalid = 1'b0;
                        w_wlast  = 1'b0;
                        w_bready = 1'b1;
                        w_beat   = '0;
                        w_state  = ST_WB;
                    end else begin
                        w_beat  = w_beat_inc;
                        w_wlast = (w_beat_inc == LAST_BEAT);
                    end
                end
            end
            ST_WB: begin
                if (s_axi_bvalid) begin
                    w_bready   = 1'b0;
                    w_resp_err = r_resp_err | s_axi_bresp[1];
                    if (w_last_burst) begin
                        w_burst   = '0;
                        w_addr    = r_base;
                        w_arvalid = 1'b1;
                        w_state   = ST_RA;
                    end else begin
                        w_burst   = r_burst + 1'b1;
                        w_addr    = r_addr + ADDR_W'(BURST_BYTES);
                        w_awvalid = 1'b1;
                        w_state   = ST_WA;
                    end
                end
            end
            ST_RA: begin
                if (s_axi_arready) begin
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                    w_beat    = '0;
                    w_state   = ST_RD;
                end
            end
            ST_RD: begin
                if (s_axi_rvalid) begin
                    w_resp_err = r_resp_err | s_axi_rresp[1];
                    if (w_mismatch) begin
                        if (r_err_cnt != {ERR_CNT_W{1'b1}})
                            w_err_cnt = r_err_cnt + 1'b1;
                        if (r_err_cnt == '0)
                            w_first_err = w_beat_addr;
                    end
                    w_beat = w_beat_inc;
                    // Burst ends on rlast or on the expected beat count, whichever first.
                    if (s_axi_rlast || w_last_beat) begin
                        w_rready = 1'b0;
                        w_beat   = '0;
                        if (w_last_burst) begin
                            w_state = ST_DONE;
                        end else begin
                            w_burst   = r_burst + 1'b1;
                            w_addr    = r_addr + ADDR_W'(BURST_BYTES);
                            w_arvalid = 1'b1;
                            w_state   = ST_RA;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                w_state = ST_IDLE;
            end
            default: w_state = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_base      <= '0;
            r_mode      <= '0;
            r_seed      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_wlast     <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_resp_err  <= 1'b0;
            r_err_cnt   <= '0;
            r_first_err <= '0;
        end else begin
            r_state     <= w_state;
            r_addr      <= w_addr;
            r_base      <= w_base;
            r_mode      <= w_mode;
            r_seed      <= w_seed;
            r_burst     <= w_burst;
            r_beat      <= w_beat;
            r_awvalid   <= w_awvalid;
            r_wvalid    <= w_wvalid;
            r_wlast     <= w_wlast;
            r_bready    <= w_bready;
            r_arvalid   <= w_arvalid;
            r_rready    <= w_rready;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_resp_err  <= w_resp_err;
            r_err_cnt   <= w_err_cnt;
            r_first_err <= w_first_err;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err;
    assign resp_err       = r_resp_err;

    assign s_axi_awaddr   = r_addr;
    assign s_axi_awlen    = 8'(BURST_LEN - 1);
    assign s_axi_awsize   = 3'(AXSIZE);
    assign s_axi_awburst  = AXI_BURST_INCR;
    assign s_axi_awcache  = AXI_CACHE_MOD;
    assign s_axi_awid     = '0;
    assign s_axi_awlock   = 1'b0;
    assign s_axi_awprot   = '0;
    assign s_axi_awqos    = '0;
    assign s_axi_awvalid  = r_awvalid;

    assign s_axi_wdata    = w_pattern;
    assign s_axi_wstrb    = '1;
    assign s_axi_wlast    = r_wlast;
    assign s_axi_wvalid   = r_wvalid;
    assign s_axi_bready   = r_bready;

    assign s_axi_araddr   = r_addr;
    assign s_axi_arlen    = 8'(BURST_LEN - 1);
    assign s_axi_arsize   = 3'(AXSIZE);
    assign s_axi_arburst  = AXI_BURST_INCR;
    assign s_axi_arcache  = AXI_CACHE_MOD;
    assign s_axi_arid     = '0;
    assign s_axi_arlock   = 1'b0;
    assign s_axi_arprot   = '0;
    assign s_axi_arqos    = '0;
    assign s_axi_arvalid  = r_arvalid;
    assign s_axi_rready   = r_rready;

    // IDs and the low response bit carry no information for this tester.
    assign w_unused = ^{s_axi_bid, s_axi_rid, s_axi_bresp[0], s_axi_rresp[0]};

endmodule

// File: tb/tb_axi_mem_burst_tester.sv
// Directed bench: behavioural AXI slave with optional stalls, bit flip, address
// aliasing and error response, driving the tester through its scenarios.
module tb_axi_mem_burst_tester;

    localparam int AW = 31;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [1:0]    mode = '0;
    logic [31:0]   seed = '0;
    logic          busy, done, resp_err;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
    logic [7:0]    s_axi_awlen, s_axi_arlen;
    logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]    s_axi_awburst, s_axi_arburst;
    logic [3:0]    s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos;
    logic [3:0]    s_axi_awid, s_axi_arid;
    logic          s_axi_awlock, s_axi_arlock, s_axi_awvalid, s_axi_arvalid;
    logic [DW-1:0] s_axi_wdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic          s_axi_wlast, s_axi_wvalid, s_axi_bready, s_axi_rready;

    logic          s_axi_awready = 1'b0;
    logic          s_axi_arready = 1'b0;
    logic          s_axi_wready  = 1'b0;
    logic [3:0]    s_axi_bid     = '0;
    logic [1:0]    s_axi_bresp   = '0;
    logic          s_axi_bvalid  = 1'b0;
    logic [DW-1:0] s_axi_rdata   = '0;
    logic [3:0]    s_axi_rid     = '0;
    logic [1:0]    s_axi_rresp   = '0;
    logic          s_axi_rlast   = 1'b0;
    logic          s_axi_rvalid  = 1'b0;

    axi_mem_burst_tester #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(4), .NUM_BURSTS(2), .ERR_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
        .resp_err(resp_err),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst), .s_axi_awcache(s_axi_awcache), .s_axi_awid(s_axi_awid),
        .s_axi_awlock(s_axi_awlock), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst), .s_axi_arcache(s_axi_arcache), .s_axi_arid(s_axi_arid),
        .s_axi_arlock(s_axi_arlock), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 clk = ~clk;

    // slave knobs and state
    bit stall_en = 0, flip_en = 0, alias_en = 0, berr_en = 0;
    logic [DW-1:0] mem [bit [31:0]];
    logic [AW-1:0] aw_q[$];
    logic [AW-1:0] ar_q[$];
    int aw_st = 0, ar_st = 0, w_st = 0, r_st = 0;
    int wbeat = 0, rbeat = 0, b_pend = 0, b_cnt = 0, rd_global = 0;
    bit b_hs = 0, r_hs = 0;
    int wlast_bad = 0, stab_bad = 0;
    logic [DW-1:0] rd_tmp;

    int total = 0, bad = 0;

    function automatic bit [31:0] mkey(input logic [AW-1:0] a);
        return {1'b0, alias_en ? (a & ~31'h100) : a};
    endfunction

    function automatic int nstall();
        return stall_en ? int'($urandom_range(5, 0)) : 0;
    endfunction

    function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
        bit [31:0] k;
        k = mkey(a);
        return mem.exists(k) ? mem[k] : '0;
    endfunction

    // Slave: decide readies/valids at negedge; a handshake lands on the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            s_axi_awready = 0; s_axi_arready = 0; s_axi_wready = 0;
            s_axi_bvalid = 0; s_axi_rvalid = 0; s_axi_rlast = 0;
            aw_q.delete(); ar_q.delete();
            wbeat = 0; rbeat = 0; b_pend = 0; b_hs = 0; r_hs = 0;
        end else begin
            if (s_axi_awready) s_axi_awready = 0;
            else if (s_axi_awvalid) begin
                if (aw_st > 0) aw_st--;
                else begin s_axi_awready = 1; aw_q.push_back(s_axi_awaddr); aw_st = nstall(); end
            end
            if (s_axi_arready) s_axi_arready = 0;
            else if (s_axi_arvalid) begin
                if (ar_st > 0) ar_st--;
                else begin s_axi_arready = 1; ar_q.push_back(s_axi_araddr); ar_st = nstall(); end
            end
            if (s_axi_wready) s_axi_wready = 0;
            else if (s_axi_wvalid && aw_q.size() > 0) begin
                if (w_st > 0) w_st--;
                else begin
                    s_axi_wready = 1;
                    mem[mkey(aw_q[0] + AW'(wbeat * 64))] = s_axi_wdata;
                    if (s_axi_wlast !== (wbeat == 3)) wlast_bad++;
                    wbeat++;
                    if (wbeat == 4) begin wbeat = 0; void'(aw_q.pop_front()); b_pend++; end
                    w_st = nstall();
                end
            end
            if (b_hs) begin s_axi_bvalid = 0; b_hs = 0; end
            else if (!s_axi_bvalid && b_pend > 0) begin
                s_axi_bvalid = 1;
                s_axi_bresp = (berr_en && b_cnt == 1) ? 2'b10 : 2'b00;
                b_cnt++; b_pend--;
            end
            if (s_axi_bvalid && s_axi_bready) b_hs = 1;
            if (r_hs) begin s_axi_rvalid = 0; r_hs = 0; end
            else if (!s_axi_rvalid && ar_q.size() > 0) begin
                if (r_st > 0) r_st--;
                else begin
                    rd_tmp = rd_mem(ar_q[0] + AW'(rbeat * 64));
                    if (flip_en && rd_global == 5) rd_tmp[3] = ~rd_tmp[3];
                    s_axi_rdata = rd_tmp;
                    s_axi_rlast = (rbeat == 3);
                    s_axi_rvalid = 1;
                    rd_global++; rbeat++;
                    if (rbeat == 4) begin rbeat = 0; void'(ar_q.pop_front()); end
                    r_st = nstall();
                end
            end
            if (s_axi_rvalid && s_axi_rready) r_hs = 1;
        end
    end

    // Master-side valid/payload must hold steady until the handshake.
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_wl = 0;
    logic [AW-1:0] p_awa = '0, p_ara = '0;
    logic [DW-1:0] p_wd = '0;
    always @(posedge clk) begin
        if (rst) begin
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (p_awv && !p_awr && (!s_axi_awvalid || s_axi_awaddr !== p_awa)) stab_bad++;
            if (p_arv && !p_arr && (!s_axi_arvalid || s_axi_araddr !== p_ara)) stab_bad++;
            if (p_wv && !p_wr && (!s_axi_wvalid || s_axi_wdata !== p_wd || s_axi_wlast !== p_wl))
                stab_bad++;
            p_awv = s_axi_awvalid; p_awr = s_axi_awready; p_awa = s_axi_awaddr;
            p_arv = s_axi_arvalid; p_arr = s_axi_arready; p_ara = s_axi_araddr;
            p_wv = s_axi_wvalid; p_wr = s_axi_wready; p_wd = s_axi_wdata; p_wl = s_axi_wlast;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [AW-1:0] b, input logic [1:0] m, input logic [31:0] s);
        b_cnt = 0; rd_global = 0;
        @(negedge clk);
        base_addr = b; mode = m; seed = s; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(negedge clk);
        end
        chk(tag, done, 1);
    endtask

    logic [DW-1:0] exp_v;

    initial begin
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_awvalid", s_axi_awvalid, 0);
        chk("rst_wvalid", s_axi_wvalid, 0);
        chk("rst_awaddr", s_axi_awaddr, 0);
        chk("rst_awlen", s_axi_awlen, 3);
        chk("rst_arsize", s_axi_arsize, 6);
        chk("rst_wstrb", s_axi_wstrb, {64{1'b1}});
        chk("rst_awcache", s_axi_awcache, 4'b0011);
        chk("rst_arburst", s_axi_arburst, 2'b01);
        @(negedge clk);
        rst = 0;

        // ideal slave, incrementing pattern
        kick(31'h0, 2'd0, 32'h10);
        chk("t1_busy", busy, 1);
        wait_done("t1_done");
        chk("t1_err_cnt", err_cnt, 0);
        chk("t1_resp_err", resp_err, 0);
        chk("t1_first_err", first_err_addr, 0);
        chk("t1_beat0", mem[32'h0], {16{32'h10}});
        chk("t1_beat7", mem[32'h1C0], {16{32'h17}});
        repeat (3) @(negedge clk);
        chk("t1_done_held", done, 1);
        chk("t1_busy_low", busy, 0);

        // walking one
        kick(31'h2000, 2'd1, 32'h0);
        wait_done("t2_done");
        exp_v = '0; exp_v[5] = 1'b1;
        chk("t2_walk5", mem[32'h2140], exp_v);
        chk("t2_err_cnt", err_cnt, 0);

        // single flipped bit on read beat 5
        flip_en = 1;
        kick(31'h1000, 2'd0, 32'h0);
        wait_done("t3_done");
        flip_en = 0;
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_first_err", first_err_addr, 31'h1140);
        chk("t3_resp_err", resp_err, 0);

        // address bit 8 ignored: burst 1 overwrites burst 0
        mem.delete();
        alias_en = 1;
        kick(31'h0, 2'd2, 32'hA5A5_0000);
        wait_done("t4_done");
        alias_en = 0;
        chk("t4_err_cnt", err_cnt, 4);
        chk("t4_first_err", first_err_addr, 0);

        // random stalls on every slave channel
        stall_en = 1;
        wlast_bad = 0; stab_bad = 0;
        kick(31'h4000, 2'd3, 32'h1234);
        wait_done("t5_done");
        stall_en = 0;
        chk("t5_err_cnt", err_cnt, 0);
        chk("t5_resp_err", resp_err, 0);
        chk("t5_beat2", mem[32'h4080], {16{32'hFFFF_EDC9}});
        chk("t5_wlast_bad", 32'(wlast_bad), 0);
        chk("t5_stable_bad", 32'(stab_bad), 0);

        // error write response on burst 1
        berr_en = 1;
        kick(31'h0, 2'd0, 32'h0);
        wait_done("t6_done");
        berr_en = 0;
        chk("t6_resp_err", resp_err, 1);
        chk("t6_err_cnt", err_cnt, 0);

        // reset in the middle of the write data phase
        kick(31'h0, 2'd0, 32'h55);
        for (int i = 0; i < 200; i++) begin
            if (s_axi_wvalid) break;
            @(negedge clk);
        end
        chk("t7_in_wd", s_axi_wvalid, 1);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("t7_awvalid", s_axi_awvalid, 0);
        chk("t7_wvalid", s_axi_wvalid, 0);
        chk("t7_bready", s_axi_bready, 0);
        chk("t7_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        kick(31'h800, 2'd0, 32'h55);
        wait_done("t7_rerun_done");
        chk("t7_rerun_err", err_cnt, 0);
        chk("t7_rerun_resp", resp_err, 0);
        chk("t7_wlast_bad", 32'(wlast_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
